execute_stack_push_seq: RTL

Multi-word stack push sequencer for the execute stage. It takes one request (start ESP, push count, word size, SS D/B bit) and issues a series of single-word stack write requests to the write stage, one word per handshake. It keeps the running stack offset itself and returns the final ESP. It serves PUSHA, real-mode INT frames and far CALL frames, so the microcode no longer has to step the stack offset datapath one micro-op at a time.

---
 rtl/execute_stack_push_seq_pkg.sv | 31 +++
 rtl/execute_stack_push_seq_step.sv | 16 +
 rtl/execute_stack_push_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/execute_stack_push_seq_pkg.sv
// Shared types and constants for the execute-stage multi-word stack push sequencer.
package execute_stack_push_seq_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned MAX_WORDS = 8;

  localparam logic [ADDR_W-1:0] WORD_BYTES_16 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] WORD_BYTES_32 = ADDR_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Request parameters captured when a sequence starts
  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic              size_32;
    logic              ss_big;
    logic [ADDR_W-1:0] esp;
  } seq_req_t;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : c;
  endfunction

endpackage

// File: rtl/execute_stack_push_seq_step.sv
// Combinational stack pointer decrement by one push word, honouring 16-bit stack wrap.
module stack_offset_step
  import execute_stack_push_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] x,
  input  logic              size_32,
  input  logic              ss_big,
  output logic [ADDR_W-1:0] next_c
);

  logic [ADDR_W-1:0] dec;

  assign dec    = x - (size_32 ? WORD_BYTES_32 : WORD_BYTES_16);
  assign next_c = ss_big ? dec : {16'd0, dec[15:0]};

endmodule

// File: rtl/execute_stack_push_seq.sv
// Issues one stack write per handshake for PUSHA / INT / far CALL frames and returns final ESP.
module execute_stack_push_seq
  import execute_stack_push_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seq_start,
  input  logic [CNT_W-1:0]  seq_count,
  input  logic              seq_size_32,
  input  logic              ss_big,
  input  logic [ADDR_W-1:0] esp,
  input  logic              seq_abort,
  output logic              seq_busy,
  output logic [IDX_W-1:0]  seq_index,
  input  logic [DATA_W-1:0] seq_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_offset,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_size_32,
  output logic              seq_done,
  output logic [ADDR_W-1:0] seq_final_esp
);

  seq_state_e        state_q, state_n;
  seq_req_t          req_q, req_n;
  logic [ADDR_W-1:0] offset_q, offset_n;
  logic [ADDR_W-1:0] final_q, final_n;
  logic [CNT_W-1:0]  idx_q, idx_n;
  logic              busy_q, busy_n;
  logic              req_out_q, req_out_n;
  logic              done_q, done_n;

  logic [ADDR_W-1:0] step_x;
  logic              step_size_32;
  logic              step_ss_big;
  logic [ADDR_W-1:0] step_next;
  logic [CNT_W-1:0]  count_clamped;

  // In IDLE the step unit pre-decrements the incoming ESP; otherwise it walks the offset register
  assign step_x       = (state_q == ST_IDLE) ? esp         : offset_q;
  assign step_size_32 = (state_q == ST_IDLE) ? seq_size_32 : req_q.size_32;
  assign step_ss_big  = (state_q == ST_IDLE) ? ss_big      : req_q.ss_big;

  stack_offset_step u_step (
    .x       (step_x),
    .size_32 (step_size_32),
    .ss_big  (step_ss_big),
    .next_c  (step_next)
  );

  assign count_clamped = clamp_count(seq_count);

  always_comb begin
    state_n  = state_q;
    req_n    = req_q;
    offset_n = offset_q;
    final_n  = final_q;
    idx_n    = idx_q;

    if (seq_abort) begin
      state_n = ST_IDLE;
      idx_n   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_n = '0;
          if (seq_start) begin
            req_n.count   = count_clamped;
            req_n.size_32 = seq_size_32;
            req_n.ss_big  = ss_big;
            req_n.esp     = esp;
            offset_n      = step_next;
            if (count_clamped == '0) begin
              state_n = ST_DONE;
              final_n = esp;
            end else begin
              state_n = ST_PUSH;
            end
          end
        end
        ST_PUSH: begin
          if (wr_ack) begin
            idx_n = idx_q + CNT_W'(1);
            if (idx_n == req_q.count) begin
              state_n = ST_DONE;
              // A 16-bit stack only updates SP; the upper half of ESP is preserved
              final_n = req_q.ss_big ? offset_q
                                     : ((req_q.esp & 32'hFFFF_0000) | (offset_q & 32'h0000_FFFF));
            end else begin
              offset_n = step_next;
            end
          end
        end
        ST_DONE: begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end
      endcase
    end

    busy_n    = (state_n != ST_IDLE);
    req_out_n = (state_n == ST_PUSH);
    done_n    = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      offset_q  <= '0;
      final_q   <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      req_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      req_q     <= req_n;
      offset_q  <= offset_n;
      final_q   <= final_n;
      idx_q     <= idx_n;
      busy_q    <= busy_n;
      req_out_q <= req_out_n;
      done_q    <= done_n;
    end
  end

  assign seq_busy      = busy_q;
  assign seq_index     = idx_q[IDX_W-1:0];
  assign wr_req        = req_out_q;
  assign wr_offset     = offset_q;
  assign wr_size_32    = req_q.size_32;
  assign seq_done      = done_q;
  assign seq_final_esp = final_q;

  // Data passes straight through from the requester, zero-extended for 16-bit words
  assign wr_data = !req_out_q    ? '0
                 : req_q.size_32 ? seq_data
                                 : {16'd0, seq_data[15:0]};

endmodule
